// File: rtl/ext_mem_host_pkg.sv
// Shared types and constants for the external-memory host initiator.
// VERIFY states exist only when EXT_MEM_HOST_VERIFY_EN is defined.
package ext_mem_host_pkg;

    localparam int IMEM_BSHIFT = 2;  // 32-bit words
    localparam int DMEM_BSHIFT = 3;  // 64-bit words

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_I,
        S_LOAD_D,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_WAIT,
        S_DUMP_OUT,
        S_DONE
`ifdef EXT_MEM_HOST_VERIFY_EN
        ,
        S_VERIFY_RD,
        S_VERIFY_WAIT
`endif
    } state_e;

endpackage

// File: rtl/host_word_counter.sv
// Loadable up-counter with a terminal-count flag (count == last).
module host_word_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)   count <= '0;
        else if (load) count <= load_val;
        else if (inc)  count <= count + W'(1);
    end

    assign tc = (count == last);

endmodule

// File: rtl/ext_mem_host.sv
// Host initiator: loads IMEM/DMEM from a word stream, runs the CPU, dumps DMEM.
// Define EXT_MEM_HOST_VERIFY_EN to add an IMEM readback XOR check (verify_err).
module ext_mem_host
    import ext_mem_host_pkg::*;
#(
    parameter int IMEM_AW    = 9,
    parameter int DMEM_AW    = 10,
    parameter int RUN_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               start,
    input  logic [IMEM_AW:0]   imem_len,
    input  logic [DMEM_AW:0]   dmem_len,
    input  logic [DMEM_AW:0]   dump_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_data,
    output logic               cpu_enable,
    output logic [63:0]        addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [31:0]        wdata_ext,
    input  logic [31:0]        rdata_ext,
    output logic [63:0]        addr_ext_2,
    output logic               wen_ext_2,
    output logic               ren_ext_2,
    output logic [63:0]        wdata_ext_2,
    input  logic [63:0]        rdata_ext_2,
    output logic               busy,
    output logic               done,
    output logic               verify_err
);

    localparam int IDX_W = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;
    localparam int RUN_W = $clog2(RUN_CYCLES + 1);

    state_e           state;
    logic [IMEM_AW:0] ilen;
    logic [DMEM_AW:0] dlen, ulen;

    logic [IDX_W-1:0] idx, idx_last;
    logic             idx_tc, idx_load, idx_inc, idx_step;
    logic [RUN_W-1:0] run_cnt;
    logic             run_tc;
    logic             hs_in, hs_out, ver_step;

    assign in_ready = (state == S_LOAD_I) || (state == S_LOAD_D);
    assign hs_in    = in_valid && in_ready;
    assign hs_out   = (state == S_DUMP_OUT) && out_ready;

`ifdef EXT_MEM_HOST_VERIFY_EN
    assign ver_step = (state == S_VERIFY_WAIT);
`else
    assign ver_step = 1'b0;
`endif

    // One index serves every phase; it returns to 0 when a phase finishes.
    assign idx_step = hs_in || hs_out || ver_step;
    assign idx_load = (state == S_IDLE) || (idx_step && idx_tc);
    assign idx_inc  = idx_step && !idx_tc;

    always_comb begin
        idx_last = '0;
        case (state)
            S_LOAD_I:                          idx_last = IDX_W'(ilen) - IDX_W'(1);
            S_LOAD_D:                          idx_last = IDX_W'(dlen) - IDX_W'(1);
            S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT: idx_last = IDX_W'(ulen) - IDX_W'(1);
`ifdef EXT_MEM_HOST_VERIFY_EN
            S_VERIFY_RD, S_VERIFY_WAIT:        idx_last = IDX_W'(ilen) - IDX_W'(1);
`endif
            default:                           idx_last = '0;
        endcase
    end

    host_word_counter #(.W(IDX_W)) u_idx (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (idx_load),
        .load_val ('0),
        .inc      (idx_inc),
        .last     (idx_last),
        .count    (idx),
        .tc       (idx_tc)
    );

    host_word_counter #(.W(RUN_W)) u_run (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (state != S_RUN),
        .load_val ('0),
        .inc      (state == S_RUN),
        .last     (RUN_W'(RUN_CYCLES - 1)),
        .count    (run_cnt),
        .tc       (run_tc)
    );

    // Memory-side strobes decode straight from state so a reset kills them at once.
    assign cpu_enable  = (state == S_RUN);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    assign wen_ext     = (state == S_LOAD_I) && in_valid;
`ifdef EXT_MEM_HOST_VERIFY_EN
    assign ren_ext     = (state == S_VERIFY_RD);
`else
    assign ren_ext     = 1'b0;
`endif
    assign wdata_ext   = wen_ext ? in_data[31:0] : '0;
    assign addr_ext    = (wen_ext || ren_ext) ? (64'(idx[IMEM_AW-1:0]) << IMEM_BSHIFT) : '0;

    assign wen_ext_2   = (state == S_LOAD_D) && in_valid;
    assign ren_ext_2   = (state == S_DUMP_RD);
    assign wdata_ext_2 = wen_ext_2 ? in_data : '0;
    assign addr_ext_2  = (wen_ext_2 || ren_ext_2) ? (64'(idx[DMEM_AW-1:0]) << DMEM_BSHIFT) : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= S_IDLE;
            ilen      <= '0;
            dlen      <= '0;
            ulen      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ilen  <= imem_len;
                    dlen  <= dmem_len;
                    ulen  <= dump_len;
                    state <= (imem_len != '0) ? S_LOAD_I :
                             (dmem_len != '0) ? S_LOAD_D : S_RUN;
                end
                S_LOAD_I: if (hs_in && idx_tc) begin
`ifdef EXT_MEM_HOST_VERIFY_EN
                    state <= S_VERIFY_RD;
`else
                    state <= (dlen != '0) ? S_LOAD_D : S_RUN;
`endif
                end
`ifdef EXT_MEM_HOST_VERIFY_EN
                S_VERIFY_RD:   state <= S_VERIFY_WAIT;
                S_VERIFY_WAIT: if (idx_tc) state <= (dlen != '0) ? S_LOAD_D : S_RUN;
                               else        state <= S_VERIFY_RD;
`endif
                S_LOAD_D: if (hs_in && idx_tc) state <= S_RUN;
                S_RUN:    if (run_tc) state <= (ulen != '0) ? S_DUMP_RD : S_DONE;
                S_DUMP_RD: state <= S_DUMP_WAIT;
                S_DUMP_WAIT: begin
                    out_data  <= rdata_ext_2;
                    out_valid <= 1'b1;
                    state     <= S_DUMP_OUT;
                end
                S_DUMP_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= idx_tc ? S_DONE : S_DUMP_RD;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef EXT_MEM_HOST_VERIFY_EN
    // Order-independent check: XOR of readback words must match XOR of loaded words.
    logic [31:0] wr_xor, rd_xor;
    logic        verr;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_xor <= '0;
            rd_xor <= '0;
            verr   <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                wr_xor <= '0;
                rd_xor <= '0;
                verr   <= 1'b0;
            end
            if (state == S_LOAD_I && hs_in) wr_xor <= wr_xor ^ in_data[31:0];
            if (state == S_VERIFY_WAIT) begin
                rd_xor <= rd_xor ^ rdata_ext;
                if (idx_tc) verr <= verr | ((rd_xor ^ rdata_ext) != wr_xor);
            end
        end
    end

    assign verify_err = verr;
`else
    logic unused_rdata;
    assign unused_rdata = ^rdata_ext;
    assign verify_err   = 1'b0;
`endif

    logic unused_run;
    assign unused_run = ^run_cnt;

endmodule

// File: tb/tb_ext_mem_host.sv
// Directed bench for ext_mem_host: memory models, queue-based expectation model, per-cycle checker.
module tb_ext_mem_host;

    localparam int IAW = 9, DAW = 10, RUNC = 1000;
    localparam int IDEP = 512, DDEP = 1024;
    localparam int IL_W = IAW + 1, DL_W = DAW + 1;

    logic            clk = 1'b0, arst_n = 1'b0, start = 1'b0;
    logic [IL_W-1:0] imem_len = '0;
    logic [DL_W-1:0] dmem_len = '0, dump_len = '0;
    logic            in_valid = 1'b0, in_ready;
    logic [63:0]     in_data = '0;
    logic            out_valid, out_ready = 1'b0;
    logic [63:0]     out_data;
    logic            cpu_enable;
    logic [63:0]     addr_ext, addr_ext_2, wdata_ext_2;
    logic            wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0]     wdata_ext, rdata_ext = '0;
    logic [63:0]     rdata_ext_2 = '0;
    logic            busy, done, verify_err;

    always #5 clk = ~clk;

    ext_mem_host #(.IMEM_AW(IAW), .DMEM_AW(DAW), .RUN_CYCLES(RUNC)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .imem_len(imem_len), .dmem_len(dmem_len), .dump_len(dump_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done), .verify_err(verify_err)
    );

    // External memories, 1-cycle read latency; bad_idx corrupts one IMEM readback word.
    logic [31:0] imem [IDEP] = '{default: '0};
    logic [63:0] dmem [DDEP] = '{default: '0};
    int          bad_idx = -1;

    always @(posedge clk) begin
        if (wen_ext)   imem[addr_ext[10:2]] <= wdata_ext;
        if (ren_ext)   rdata_ext <= (int'(addr_ext[10:2]) == bad_idx) ? 32'hFFFF_FFFF : imem[addr_ext[10:2]];
        if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    typedef struct packed { logic [63:0] a; logic [63:0] d; } wr_t;
    wr_t         exp_iw[$], exp_dw[$];
    logic [63:0] exp_dump[$];
    logic [31:0] sh_i [IDEP] = '{default: '0};
    logic [63:0] sh_d [DDEP] = '{default: '0};
    bit          exp_verr = 1'b0;
    logic [63:0] iw_log[$], dump_log[$];
    logic [31:0] wi[$];
    logic [63:0] wd[$];
    int          run_cnt = 0, run_last = 0;
    int          checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle checker, sampled on the falling edge.
    wr_t         ce;
    logic        pv_valid = 1'b0, pv_ready = 1'b0, p_done = 1'b0;
    logic [63:0] pv_data = '0;

    always @(negedge clk) begin
        if (!arst_n) begin
            run_cnt  = 0;
            pv_valid = 1'b0;
            p_done   = 1'b0;
        end else begin
            if (wen_ext) begin
                chk("imem_wr_handshake", 64'(in_valid & in_ready), 64'd1);
                iw_log.push_back(addr_ext);
                if (exp_iw.size() == 0) chk("imem_wr_unexpected", 64'd1, 64'd0);
                else begin
                    ce = exp_iw.pop_front();
                    chk("imem_wr_addr", addr_ext, ce.a);
                    chk("imem_wr_data", 64'(wdata_ext), ce.d);
                end
            end
            if (wen_ext_2) begin
                chk("dmem_wr_handshake", 64'(in_valid & in_ready), 64'd1);
                if (exp_dw.size() == 0) chk("dmem_wr_unexpected", 64'd1, 64'd0);
                else begin
                    ce = exp_dw.pop_front();
                    chk("dmem_wr_addr", addr_ext_2, ce.a);
                    chk("dmem_wr_data", wdata_ext_2, ce.d);
                end
            end
            if (cpu_enable) begin
                run_cnt++;
                chk("mem_idle_in_run", 64'({wen_ext, ren_ext, wen_ext_2, ren_ext_2, in_ready}), 64'd0);
            end
            if (pv_valid && !pv_ready) begin
                chk("out_valid_hold", 64'(out_valid), 64'd1);
                chk("out_data_hold", out_data, pv_data);
            end
            if (out_valid && out_ready) begin
                dump_log.push_back(out_data);
                if (exp_dump.size() == 0) chk("dump_unexpected", 64'd1, 64'd0);
                else chk("dump_data", out_data, exp_dump.pop_front());
            end
            if (done) begin
                chk("run_cycles", 64'(run_cnt), 64'(RUNC));
                run_last = run_cnt;
                run_cnt  = 0;
                chk("busy_at_done", 64'(busy), 64'd1);
                chk("model_drained", 64'(exp_iw.size() + exp_dw.size() + exp_dump.size()), 64'd0);
                chk("verify_err_at_done", 64'(verify_err), 64'(exp_verr));
            end
            if (p_done) chk("busy_after_done", 64'(busy), 64'd0);
            pv_valid = out_valid;
            pv_ready = out_ready;
            pv_data  = out_data;
            p_done   = done;
        end
    end

    // Build expectations from wi/wd, drive one sequence; abort_at>0 resets mid-RUN.
    task automatic do_seq(input int il, input int dl, input int ul, input bit gap,
                          input int hold, input int abort_at);
        wr_t         t;
        logic [31:0] wx, rx;
        int          n;
        bit          seen;
        wx = '0;
        rx = '0;
        for (int i = 0; i < il; i++) begin
            t.a = 64'((i % IDEP) * 4);
            t.d = 64'(wi[i]);
            exp_iw.push_back(t);
            sh_i[i % IDEP] = wi[i];
            wx ^= wi[i];
        end
        for (int i = 0; i < il; i++)
            rx ^= ((i % IDEP) == bad_idx) ? 32'hFFFF_FFFF : sh_i[i % IDEP];
`ifdef EXT_MEM_HOST_VERIFY_EN
        exp_verr = (il > 0) && (wx != rx);
`else
        exp_verr = 1'b0;
`endif
        for (int i = 0; i < dl; i++) begin
            t.a = 64'((i % DDEP) * 8);
            t.d = wd[i];
            exp_dw.push_back(t);
            sh_d[i % DDEP] = wd[i];
        end
        for (int j = 0; j < ul; j++) exp_dump.push_back(sh_d[j % DDEP]);

        imem_len  = IL_W'(il);
        dmem_len  = DL_W'(dl);
        dump_len  = DL_W'(ul);
        out_ready = (hold == 0);
        start = 1'b1;
        tick();
        start = 1'b0;

        for (int k = 0; k < il + dl; k++) begin
            in_valid = 1'b1;
            in_data  = (k < il) ? {32'hA5A5_0000 ^ 32'(k), wi[k]} : wd[k - il];
            n = 0;
            do begin
                seen = in_ready;
                tick();
                n++;
            end while (!seen && n < 3000);
            if (!seen) chk("in_ready_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            in_data  = '0;
            if (gap) tick();
        end

        if (abort_at > 0) begin
            n = 0;
            while (!cpu_enable && n < 5000) begin tick(); n++; end
            repeat (abort_at) tick();
            arst_n = 1'b0;
            #2;
            chk("rst_async_outputs", 64'({cpu_enable, busy, in_ready, out_valid, done}), 64'd0);
            tick();
            arst_n = 1'b1;
            exp_dump.delete();
            tick();
            return;
        end

        if (hold > 0) begin
            n = 0;
            while (!out_valid && n < 5000) begin tick(); n++; end
            repeat (hold) tick();
            out_ready = 1'b1;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8000) begin
            seen = done;
            tick();
            n++;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        out_ready = 1'b0;
        tick();
    endtask

    logic [63:0] lit_addr [4] = '{64'd0, 64'd4, 64'd8, 64'd12};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({in_ready, out_valid, cpu_enable, wen_ext, ren_ext, wen_ext_2,
                             ren_ext_2, busy, done, verify_err}), 64'd0);
        chk("rst_addr", addr_ext | addr_ext_2, 64'd0);
        chk("rst_data", out_data | wdata_ext_2 | 64'(wdata_ext), 64'd0);
        arst_n = 1'b1;
        tick();
        chk("idle_after_rst", 64'({busy, cpu_enable, in_ready}), 64'd0);

        // four NOPs into IMEM, no data, no dump
        wi = '{32'h13, 32'h13, 32'h13, 32'h13};
        iw_log.delete();
        do_seq(4, 0, 0, 1'b0, 0, 0);
        chk("t1_wr_count", 64'(iw_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_wr_addr_lit", iw_log[i], lit_addr[i]);
        chk("t1_run_1000", 64'(run_last), 64'd1000);

        // DMEM load + dump, out_ready held high
        wd = '{64'hDEAD, 64'hBEEF};
        dump_log.delete();
        do_seq(0, 2, 2, 1'b0, 0, 0);
        chk("t2_dump_count", 64'(dump_log.size()), 64'd2);
        chk("t2_dump0_lit", dump_log[0], 64'hDEAD);
        chk("t2_dump1_lit", dump_log[1], 64'hBEEF);

        // backpressure: out_ready low for 10 cycles
        wd = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5555_AAAA_0F0F_F0F0};
        dump_log.delete();
        do_seq(0, 3, 3, 1'b0, 10, 0);
        chk("t3_dump0_lit", dump_log[0], 64'h0123_4567_89AB_CDEF);

        // in_valid toggling during LOAD_I
        wi = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        wd = '{64'hCAFE_F00D_0000_0001};
        iw_log.delete();
        do_seq(4, 1, 1, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) chk("t4_wr_addr_lit", iw_log[i], lit_addr[i]);

        // reset during RUN, then a complete sequence
        wi = '{32'h0000_0093, 32'h0000_0113};
        wd = '{64'h7777};
        do_seq(2, 1, 1, 1'b0, 0, 100);
        wd = '{64'h9999_0000, 64'h8888_0000};
        dump_log.delete();
        do_seq(2, 2, 3, 1'b0, 0, 0);
        chk("t6_dump2_lit", dump_log[2], 64'h5555_AAAA_0F0F_F0F0);

        // IMEM length past depth: index wraps
        wi.delete();
        for (int i = 0; i < IDEP + 2; i++) wi.push_back(32'(i) * 32'h0101_0101 + 32'h7);
        iw_log.delete();
        do_seq(IDEP + 2, 0, 0, 1'b0, 0, 0);
        chk("t7_wrap_addr_lit", iw_log[IDEP], 64'd0);
        chk("t7_wrap_addr1_lit", iw_log[IDEP + 1], 64'd4);

`ifdef EXT_MEM_HOST_VERIFY_EN
        bad_idx = 1;
        wi = '{32'h10, 32'h20, 32'h30};
        do_seq(3, 0, 0, 1'b0, 0, 0);
        chk("verr_sticky_lit", 64'(verify_err), 64'd1);
        bad_idx = -1;
        wd = '{64'h42};
        do_seq(0, 1, 0, 1'b0, 0, 0);
        chk("verr_cleared_lit", 64'(verify_err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

endmodule
